// File: rtl/link_sched_pkg.sv
// Shared types and limits for the link scheduler arbiter.
// The DROP state exists only when LINK_SCHED_TIMEOUT_EN is defined.
package link_sched_pkg;

  localparam int N_REQ_MAX = 16;
  localparam int IDX_W     = 4;

  typedef logic [31:0]      payload_t;
  typedef logic [IDX_W-1:0] idx_t;

`ifdef LINK_SCHED_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/link_sched_arb_if.sv
// Requester and downstream handshake bundle for link_sched_arb; slave is the arbiter side.
// o_tmo_err is present only when LINK_SCHED_TIMEOUT_EN is defined.
interface link_sched_arb_if #(
  parameter int N_REQ = 4
) ();
  import link_sched_pkg::*;

  logic     [N_REQ-1:0] i_req_wen;
  payload_t [N_REQ-1:0] i_req_token;
  payload_t [N_REQ-1:0] i_req_id;
  logic     [N_REQ-1:0] o_req_ack;
  logic                 o_wen_down;
  payload_t             o_token_down;
  payload_t             o_clk_cnt_down;
  payload_t             o_id_down;
  logic                 i_ready_down;
  idx_t                 o_grant_idx;
  logic                 o_busy;
`ifdef LINK_SCHED_TIMEOUT_EN
  logic                 o_tmo_err;
`endif

  modport slave (
    input  i_req_wen, i_req_token, i_req_id, i_ready_down,
    output o_req_ack, o_wen_down, o_token_down, o_clk_cnt_down, o_id_down,
           o_grant_idx, o_busy
`ifdef LINK_SCHED_TIMEOUT_EN
  , output o_tmo_err
`endif
  );

  modport master (
    output i_req_wen, i_req_token, i_req_id, i_ready_down,
    input  o_req_ack, o_wen_down, o_token_down, o_clk_cnt_down, o_id_down,
           o_grant_idx, o_busy
`ifdef LINK_SCHED_TIMEOUT_EN
  , input  o_tmo_err
`endif
  );

endinterface

// File: rtl/link_rr_arb.sv
// Combinational round-robin pick: first set request at or after i_ptr, modulo N_REQ.
// Zero latency; no backpressure, o_any flags that o_idx is meaningful.
module link_rr_arb
  import link_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  idx_t             i_ptr,
  output idx_t             o_idx,
  output logic             o_any
);

  logic [N_REQ_MAX-1:0] req_pad;
  logic [IDX_W:0]       pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    req_pad = N_REQ_MAX'(i_req);
    o_idx   = '0;
    o_any   = 1'b0;
    pos     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, i_ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(N_REQ)) begin
        pos = pos - (IDX_W + 1)'(N_REQ);
      end
      if (req_pad[pos[IDX_W-1:0]]) begin
        o_idx = pos[IDX_W-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_sched_arb.sv
// Round-robin scheduler of N_REQ link requesters onto one downstream channel; valid 1 cycle after grant.
// Payload held until i_ready_down; LINK_SCHED_TIMEOUT_EN drops a grant stalled TMO_CYC cycles.
module link_sched_arb
  import link_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TMO_CYC = 64
) (
  input logic             i_clk,
  input logic             i_rst,
  link_sched_arb_if.slave bus
);

  if (N_REQ < 2 || N_REQ > N_REQ_MAX || TMO_CYC < 1) begin : g_bad_param
    $error("link_sched_arb: parameter out of range");
  end

  state_t   state_q, state_d;
  idx_t     rr_ptr_q, rr_ptr_d;
  idx_t     grant_q, grant_d;
  payload_t token_q, token_d;
  payload_t id_q, id_d;
  payload_t stamp_q, stamp_d;
  payload_t cnt_q, cnt_d;
  idx_t     arb_idx;
  idx_t     ptr_next;
  logic     arb_any;
  logic     rel_grant;
  payload_t sel_token, sel_id;

`ifdef LINK_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;
`endif

  link_rr_arb #(.N_REQ(N_REQ)) u_rr (
    .i_req (bus.i_req_wen),
    .i_ptr (rr_ptr_q),
    .o_idx (arb_idx),
    .o_any (arb_any)
  );

  always_comb begin
    sel_token = '0;
    sel_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_idx == idx_t'(k)) begin
        sel_token = bus.i_req_token[k];
        sel_id    = bus.i_req_id[k];
      end
    end
  end

  assign ptr_next = (grant_q == idx_t'(N_REQ - 1)) ? '0 : grant_q + idx_t'(1);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    token_d   = token_q;
    id_d      = id_q;
    stamp_d   = stamp_q;
    cnt_d     = cnt_q + 32'd1;
    rel_grant = 1'b0;
`ifdef LINK_SCHED_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          token_d = sel_token;
          id_d    = sel_id;
          stamp_d = cnt_q;
          state_d = ST_SEND;
`ifdef LINK_SCHED_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_SEND: begin
        if (bus.i_ready_down) begin
          rel_grant = 1'b1;
          rr_ptr_d  = ptr_next;
          state_d   = ST_IDLE;
        end
`ifdef LINK_SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
          state_d   = ST_DROP;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
`ifdef LINK_SCHED_TIMEOUT_EN
      // Ack without a transfer so the stalled requester lets go.
      ST_DROP: begin
        rel_grant = 1'b1;
        rr_ptr_d  = ptr_next;
        state_d   = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset in flight cancels the ack so an aborted grant is retried, not lost.
  always_comb begin
    bus.o_req_ack = '0;
    for (int k = 0; k < N_REQ; k++) begin
      bus.o_req_ack[k] = rel_grant && !i_rst && (grant_q == idx_t'(k));
    end
  end

  assign bus.o_busy         = (state_q == ST_SEND);
  assign bus.o_wen_down     = bus.o_busy;
  assign bus.o_token_down   = bus.o_busy ? token_q : '0;
  assign bus.o_id_down      = bus.o_busy ? id_q    : '0;
  assign bus.o_clk_cnt_down = bus.o_busy ? stamp_q : '0;
  assign bus.o_grant_idx    = grant_q;
`ifdef LINK_SCHED_TIMEOUT_EN
  assign bus.o_tmo_err      = tmo_err_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      token_q  <= '0;
      id_q     <= '0;
      stamp_q  <= '0;
      cnt_q    <= '0;
`ifdef LINK_SCHED_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      token_q  <= token_d;
      id_q     <= id_d;
      stamp_q  <= stamp_d;
      cnt_q    <= cnt_d;
`ifdef LINK_SCHED_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_link_sched_arb.sv
// Directed bench for link_sched_arb: round-robin order, stall, counter wrap, reset abort, timeout.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_link_sched_arb;
  import link_sched_pkg::*;

`ifdef LINK_SCHED_TIMEOUT_EN
  localparam int HOLD = 6;
`else
  localparam int HOLD = 10;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] cyc;
  int          checks;
  int          errors;

  link_sched_arb_if #(.N_REQ(4)) bus ();

  link_sched_arb #(.N_REQ(4), .TMO_CYC(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc = cyc + 32'd1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wen"},   32'(bus.o_wen_down),     32'd0);
    chk({tag, "_ack"},   32'(bus.o_req_ack),      32'd0);
    chk({tag, "_busy"},  32'(bus.o_busy),         32'd0);
    chk({tag, "_token"}, bus.o_token_down,        32'd0);
    chk({tag, "_id"},    bus.o_id_down,           32'd0);
    chk({tag, "_cnt"},   bus.o_clk_cnt_down,      32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = '0;
    rst    = 1'b1;
    bus.i_req_wen    = '0;
    bus.i_req_token  = '0;
    bus.i_req_id     = '0;
    bus.i_ready_down = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_grant_idx", 32'(bus.o_grant_idx), 32'd0);
`ifdef LINK_SCHED_TIMEOUT_EN
    chk("reset_tmo_err", 32'(bus.o_tmo_err), 32'd0);
`endif

    // All four requesting continuously: 0,1,2,3,0 with a bubble between grants.
    @(negedge clk);
    rst = 1'b0;
    cyc = '0;
    for (int k = 0; k < 4; k++) begin
      bus.i_req_token[k] = 32'h1000_0000 + 32'(k);
      bus.i_req_id[k]    = 32'h2000_0000 + 32'(k);
    end
    bus.i_req_wen    = 4'hF;
    bus.i_ready_down = 1'b1;
    #1;
    chk("rr_first_idle_wen", 32'(bus.o_wen_down), 32'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      #1;
      chk("rr_wen",   32'(bus.o_wen_down),  32'd1);
      chk("rr_grant", 32'(bus.o_grant_idx), 32'(n % 4));
      chk("rr_ack",   32'(bus.o_req_ack),   32'd1 << (n % 4));
      chk("rr_token", bus.o_token_down,     32'h1000_0000 + 32'(n % 4));
      chk("rr_id",    bus.o_id_down,        32'h2000_0000 + 32'(n % 4));
      chk("rr_stamp", bus.o_clk_cnt_down,   32'(2 * n));
      if (n == 4) bus.i_req_wen = 4'h0;
      tick();
      #1;
      chk("rr_bubble_wen", 32'(bus.o_wen_down), 32'd0);
      chk("rr_bubble_ack", 32'(bus.o_req_ack),  32'd0);
    end

    // Single requester 2 (pointer is 1 here).
    tick();
    bus.i_req_token[2] = 32'hA5A5_0001;
    bus.i_req_id[2]    = 32'h0000_0C02;
    bus.i_req_wen      = 4'b0100;
    #1;
    chk("single_idle_wen", 32'(bus.o_wen_down), 32'd0);
    tick();
    #1;
    chk("single_wen",   32'(bus.o_wen_down),  32'd1);
    chk("single_token", bus.o_token_down,     32'hA5A5_0001);
    chk("single_id",    bus.o_id_down,        32'h0000_0C02);
    chk("single_ack",   32'(bus.o_req_ack),   32'b0100);
    chk("single_grant", 32'(bus.o_grant_idx), 32'd2);
    bus.i_req_wen = 4'b0000;
    tick();
    #1;
    chk_quiet("single_after");
    chk("single_after_grant", 32'(bus.o_grant_idx), 32'd2);

    // Stall: requester 1 (pointer 3 scans 3,0,1), ready low for HOLD cycles.
    tick();
    bus.i_req_token[1] = 32'hBEEF_0001;
    bus.i_req_id[1]    = 32'h0000_0B01;
    bus.i_req_wen      = 4'b0010;
    bus.i_ready_down   = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      #1;
      chk("stall_wen",   32'(bus.o_wen_down), 32'd1);
      chk("stall_token", bus.o_token_down,    32'hBEEF_0001);
      chk("stall_id",    bus.o_id_down,       32'h0000_0B01);
      chk("stall_ack",   32'(bus.o_req_ack),  32'd0);
    end
    tick();
    #1;
    chk("stall_ack_before_ready", 32'(bus.o_req_ack), 32'd0);
    bus.i_ready_down = 1'b1;
    #1;
    chk("stall_ack_on_ready",   32'(bus.o_req_ack),  32'b0010);
    chk("stall_token_on_ready", bus.o_token_down,    32'hBEEF_0001);
    bus.i_req_wen = 4'b0000;
    tick();
    #1;
    chk_quiet("stall_after");

    // Counter wrap: park the free-running counter at 0xFFFFFFFF, pointer is 2.
    tick();
    force dut.cnt_q = 32'hFFFF_FFFE;
    tick();
    force dut.cnt_q = 32'hFFFF_FFFF;
    release dut.cnt_q;
    cyc = 32'hFFFF_FFFF;
    bus.i_req_wen = 4'b0001;
    #1;
    chk("wrap_idle_wen", 32'(bus.o_wen_down), 32'd0);
    tick();
    #1;
    chk("wrap_stamp_max", bus.o_clk_cnt_down,   32'hFFFF_FFFF);
    chk("wrap_grant0",    32'(bus.o_grant_idx), 32'd0);
    chk("wrap_ack0",      32'(bus.o_req_ack),   32'b0001);
    tick();
    #1;
    chk("wrap_bubble_wen", 32'(bus.o_wen_down), 32'd0);
    tick();
    #1;
    chk("wrap_stamp_small", bus.o_clk_cnt_down,   32'h0000_0001);
    chk("wrap_grant1",      32'(bus.o_grant_idx), 32'd0);
    bus.i_req_wen = 4'b0000;
    tick();
    #1;
    chk_quiet("wrap_after");

    // Reset while requester 3 is in SEND (pointer 1 scans 1,2,3).
    tick();
    bus.i_req_wen    = 4'b1000;
    bus.i_ready_down = 1'b0;
    tick();
    #1;
    chk("rstsend_busy",  32'(bus.o_busy),      32'd1);
    chk("rstsend_grant", 32'(bus.o_grant_idx), 32'd3);
    rst = 1'b1;
    bus.i_ready_down = 1'b1;
    #1;
    chk("rstsend_no_ack", 32'(bus.o_req_ack), 32'd0);
    tick();
    #1;
    chk_quiet("rstsend_after");
    chk("rstsend_grant_cleared", 32'(bus.o_grant_idx), 32'd0);
    rst = 1'b0;
    cyc = '0;
    bus.i_req_wen = 4'b1001;
    tick();
    #1;
    chk("retry_grant_ptr0", 32'(bus.o_grant_idx), 32'd0);
    chk("retry_ack0",       32'(bus.o_req_ack),   32'b0001);
    chk("retry_stamp0",     bus.o_clk_cnt_down,   32'd0);
    bus.i_req_wen = 4'b1000;
    tick();
    #1;
    chk("retry_bubble_wen", 32'(bus.o_wen_down), 32'd0);
    tick();
    #1;
    chk("retry_grant3", 32'(bus.o_grant_idx), 32'd3);
    chk("retry_token3", bus.o_token_down,     32'h1000_0003);
    chk("retry_ack3",   32'(bus.o_req_ack),   32'b1000);
    bus.i_req_wen = 4'b0000;
    tick();
    #1;
    chk_quiet("retry_after");

`ifdef LINK_SCHED_TIMEOUT_EN
    // Timeout: requester 2 stalls 8 cycles, gets dropped, requester 3 is next.
    tick();
    bus.i_req_wen    = 4'b0100;
    bus.i_ready_down = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      chk("tmo_send_wen", 32'(bus.o_wen_down), 32'd1);
      chk("tmo_send_ack", 32'(bus.o_req_ack),  32'd0);
      chk("tmo_send_err", 32'(bus.o_tmo_err),  32'd0);
    end
    tick();
    #1;
    chk("tmo_drop_wen", 32'(bus.o_wen_down), 32'd0);
    chk("tmo_drop_ack", 32'(bus.o_req_ack),  32'b0100);
    chk("tmo_drop_err", 32'(bus.o_tmo_err),  32'd1);
    bus.i_req_wen    = 4'b1000;
    bus.i_ready_down = 1'b1;
    tick();
    #1;
    chk("tmo_idle_ack",    32'(bus.o_req_ack), 32'd0);
    chk("tmo_idle_sticky", 32'(bus.o_tmo_err), 32'd1);
    tick();
    #1;
    chk("tmo_next_grant", 32'(bus.o_grant_idx), 32'd3);
    chk("tmo_next_ack",   32'(bus.o_req_ack),   32'b1000);
    bus.i_req_wen = 4'b0000;
    tick();
    #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_sched_arb.md
LINK_SCHED_ARB -- requirements
Module: link_sched_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requester link channels (2..16).
REQ-002 Parameter TMO_CYC, default 64, ready-timeout in cycles; used only with LINK_SCHED_TIMEOUT_EN.
REQ-003 i_clk  in  1  single clock; all logic on posedge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_req_wen  in  N_REQ  per-requester valid; held high until the matching ack.
REQ-006 i_req_token  in  N_REQ x 32  per-requester token payload.
REQ-007 i_req_id  in  N_REQ x 32  per-requester id payload.
REQ-008 o_req_ack  out  N_REQ  one-hot, one-cycle pulse on transfer of that requester.
REQ-009 o_wen_down  out  1  shared downstream valid.
REQ-010 o_token_down, o_clk_cnt_down, o_id_down  out  32 each  shared downstream payload.
REQ-011 i_ready_down  in  1  downstream accept; transfer = o_wen_down and i_ready_down.
REQ-012 o_grant_idx  out  4  index of the current or last granted requester.
REQ-013 o_busy  out  1  high while state is SEND.

Function
REQ-014 FSM states: IDLE, SEND; with LINK_SCHED_TIMEOUT_EN, also DROP.
REQ-015 Free-running 32-bit cycle counter; increments every cycle; wraps 0xFFFFFFFF->0.
REQ-016 IDLE: if any i_req_wen, grant the first set requester at or after rr_ptr (modulo N_REQ), latch its token and id, stamp the counter value into o_clk_cnt_down, go to SEND.
REQ-017 Grant-to-valid latency: request sampled at edge t; o_wen_down high from t+1.
REQ-018 SEND: o_wen_down=1, payload stable; on transfer, o_req_ack[grant] is 1 combinationally that cycle, rr_ptr=grant+1 (N_REQ-1 wraps to 0), next state IDLE.
REQ-019 Maximum throughput is one transfer per 2 cycles; the IDLE bubble is mandatory.
REQ-020 A requester dropping i_req_wen while granted in SEND does not cancel the transfer; the latched payload completes.
REQ-021 Requesters not granted see o_req_ack=0; no requester is granted twice before every other pending requester has been granted once.
REQ-022 Outside SEND: o_wen_down=0 and o_token_down, o_id_down, o_clk_cnt_down=0.
REQ-023 o_req_ack is never asserted outside a transfer cycle.

Reset
REQ-024 Reset: state IDLE, rr_ptr=0, counter=0, o_grant_idx=0, all outputs 0.
REQ-025 Reset asserted in SEND aborts the transfer without an ack; the requester retries after reset.

Configuration
REQ-026 LINK_SCHED_TIMEOUT_EN defined: in SEND, count cycles with i_ready_down low; at TMO_CYC, enter DROP.
REQ-027 DROP lasts 1 cycle: o_wen_down=0; o_req_ack[grant] pulses so the requester releases; rr_ptr advances; next state IDLE; sticky o_tmo_err output is set and cleared only by reset.
REQ-028 LINK_SCHED_TIMEOUT_EN undefined: SEND waits indefinitely; no DROP state and no o_tmo_err port exist.

Structure
REQ-029 Package link_sched_pkg holds the state enum, the 32-bit payload typedef, and the N_REQ maximum constant.
REQ-030 Round-robin selection lives in the sub-module link_rr_arb (inputs: request vector and pointer; outputs: grant index and any-valid), which is purely combinational.

Verification
REQ-031 Single requester 2, token 0xA5A5_0001, ready=1 -> o_wen_down at t+1 with token 0xA5A5_0001, o_req_ack=4'b0100, back to IDLE.
REQ-032 All 4 requesting continuously, ready=1 -> grant order 0,1,2,3,0; transfers every 2 cycles.
REQ-033 Ready held low for 10 cycles in SEND -> payload stable for 10 cycles; ack only on the cycle ready rises.
REQ-034 Counter preset near wrap: grant stamped at 0xFFFFFFFF, then the next grant stamps a small value after wrap.
REQ-035 Reset pulsed while in SEND -> no ack; all outputs 0 the next cycle; rr_ptr=0.
REQ-036 LINK_SCHED_TIMEOUT_EN, TMO_CYC=8, ready stuck low -> DROP after 8 cycles; ack pulse; o_tmo_err=1; next requester is served.
